// File: rtl/x86_uop_decoder_pkg.sv
// Shared widths, micro-op codes, x86 opcode bytes and decoder states for the
// byte-serial x86-64 micro-op decoder.
package x86_uop_decoder_pkg;

    localparam int OPCODE_W   = 4;
    localparam int IMM_W      = 32;
    localparam int DISP_W     = 32;
    localparam int BIT_MODE_W = 2;

    // Micro-op codes; zero is reserved for an illegal instruction.
    localparam logic [OPCODE_W-1:0] MICRO_NONE = 4'd0;
    localparam logic [OPCODE_W-1:0] MICRO_ADD  = 4'd1;
    localparam logic [OPCODE_W-1:0] MICRO_ADDI = 4'd2;
    localparam logic [OPCODE_W-1:0] MICRO_SLLI = 4'd3;
    localparam logic [OPCODE_W-1:0] MICRO_XOR  = 4'd4;
    localparam logic [OPCODE_W-1:0] MICRO_MOV  = 4'd5;
    localparam logic [OPCODE_W-1:0] MICRO_MOVI = 4'd6;
    localparam logic [OPCODE_W-1:0] MICRO_LEA  = 4'd7;

    localparam logic [BIT_MODE_W-1:0] BIT_MODE_16 = 2'd1;
    localparam logic [BIT_MODE_W-1:0] BIT_MODE_32 = 2'd2;
    localparam logic [BIT_MODE_W-1:0] BIT_MODE_64 = 2'd3;

    // x86 opcode / prefix bytes understood by the decoder.
    localparam logic [7:0] X86_PFX_OPSZ  = 8'h66;
    localparam logic [7:0] X86_ADD_RM_R  = 8'h01;
    localparam logic [7:0] X86_XOR_RM_R  = 8'h31;
    localparam logic [7:0] X86_MOV_RM_R  = 8'h89;
    localparam logic [7:0] X86_LEA       = 8'h8D;
    localparam logic [7:0] X86_GRP1_IZ   = 8'h81;
    localparam logic [7:0] X86_GRP1_IB   = 8'h83;
    localparam logic [7:0] X86_GRP2_IB   = 8'hC1;
    localparam logic [7:0] X86_MOV_RM_IZ = 8'hC7;
    localparam logic [7:0] X86_MOV_R_IMM = 8'hB8;

    // Displacement size selector.
    localparam logic [1:0] DISP_NONE = 2'd0;
    localparam logic [1:0] DISP_8    = 2'd1;
    localparam logic [1:0] DISP_32   = 2'd2;

    // Decoder states.
    localparam logic [2:0] S_OP    = 3'd0;
    localparam logic [2:0] S_MODRM = 3'd1;
    localparam logic [2:0] S_DISP  = 3'd2;
    localparam logic [2:0] S_IMM   = 3'd3;
    localparam logic [2:0] S_EMIT  = 3'd4;

    // Bytes arrive little-endian and are shifted in from the top, so after
    // n bytes the value sits in the upper n bytes of the word.
    function automatic logic [31:0] le_assemble(input logic [31:0] shifted,
                                                input logic [2:0]  nbytes,
                                                input logic        sign_ext);
        logic [31:0] res;
        case (nbytes)
            3'd1:    res = {{24{sign_ext & shifted[31]}}, shifted[31:24]};
            3'd2:    res = {{16{sign_ext & shifted[31]}}, shifted[31:16]};
            default: res = shifted;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/x86_opcode_classify.sv
// Combinational opcode/ModRM classifier: maps an opcode byte (and its ModRM
// byte once available) to micro-op, operand layout and legality.
module x86_opcode_classify
    import x86_uop_decoder_pkg::*;
(
    input  logic [7:0]          opcode,
    input  logic [7:0]          modrm,
    input  logic                modrm_valid,
    input  logic                rex_w,
    input  logic                opsz16,
    output logic [OPCODE_W-1:0] micro,
    output logic                needs_modrm,
    output logic [1:0]          disp_sel,
    output logic [2:0]          imm_bytes,
    output logic                imm_signed,
    output logic                illegal
);

    logic [1:0]          mod_s;
    logic [2:0]          digit_s;
    logic [2:0]          rm_s;
    logic                reg_bad_s;
    logic [2:0]          imm_z_s;
    logic [OPCODE_W-1:0] micro_raw_s;

    // Decode opcode class; ModRM-dependent checks only apply once modrm_valid.
    always_comb begin
        mod_s       = modrm[7:6];
        digit_s     = modrm[5:3];
        rm_s        = modrm[2:0];
        reg_bad_s   = modrm_valid && (mod_s != 2'b11);
        imm_z_s     = (opsz16 && !rex_w) ? 3'd2 : 3'd4;
        micro_raw_s = MICRO_NONE;
        needs_modrm = 1'b1;
        disp_sel    = DISP_NONE;
        imm_bytes   = 3'd0;
        imm_signed  = 1'b1;
        illegal     = 1'b0;
        case (opcode)
            X86_ADD_RM_R: begin
                micro_raw_s = MICRO_ADD;
                illegal     = reg_bad_s;
            end
            X86_XOR_RM_R: begin
                micro_raw_s = MICRO_XOR;
                illegal     = reg_bad_s;
            end
            X86_MOV_RM_R: begin
                micro_raw_s = MICRO_MOV;
                illegal     = reg_bad_s;
            end
            X86_LEA: begin
                micro_raw_s = MICRO_LEA;
                // Register form, SIB and RIP-relative addressing are unsupported.
                illegal     = modrm_valid && ((mod_s == 2'b11) || (rm_s == 3'b100) ||
                                              ((mod_s == 2'b00) && (rm_s == 3'b101)));
                disp_sel    = (mod_s == 2'b01) ? DISP_8 :
                              (mod_s == 2'b10) ? DISP_32 : DISP_NONE;
            end
            X86_GRP1_IZ: begin
                micro_raw_s = MICRO_ADDI;
                imm_bytes   = imm_z_s;
                illegal     = reg_bad_s || (modrm_valid && (digit_s != 3'd0));
            end
            X86_GRP1_IB: begin
                micro_raw_s = MICRO_ADDI;
                imm_bytes   = 3'd1;
                illegal     = reg_bad_s || (modrm_valid && (digit_s != 3'd0));
            end
            X86_GRP2_IB: begin
                micro_raw_s = MICRO_SLLI;
                imm_bytes   = 3'd1;
                imm_signed  = 1'b0;
                illegal     = reg_bad_s || (modrm_valid && (digit_s != 3'd4));
            end
            X86_MOV_RM_IZ: begin
                micro_raw_s = MICRO_MOVI;
                imm_bytes   = imm_z_s;
                illegal     = reg_bad_s || (modrm_valid && (digit_s != 3'd0));
            end
            default: begin
                needs_modrm = 1'b0;
                if ((opcode & 8'hF8) == X86_MOV_R_IMM) begin
                    // B8+r carries imm64 under REX.W, which is not supported.
                    micro_raw_s = MICRO_MOVI;
                    imm_bytes   = imm_z_s;
                    illegal     = rex_w;
                end else begin
                    illegal     = 1'b1;
                end
            end
        endcase
    end

    assign micro = illegal ? MICRO_NONE : micro_raw_s;

endmodule

// File: rtl/x86_uop_decoder.sv
// Byte-serial x86-64 decoder: consumes prefix/opcode/ModRM/disp/imm bytes one
// per cycle and presents one registered micro-op per instruction.
module x86_uop_decoder
    import x86_uop_decoder_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_byte,
    output logic                  uop_valid,
    input  logic                  uop_ready,
    output logic [OPCODE_W-1:0]   uop_opcode,
    output logic [3:0]            uop_rd,
    output logic [3:0]            uop_rs,
    output logic [3:0]            uop_rt,
    output logic [IMM_W-1:0]      uop_imm,
    output logic [DISP_W-1:0]     uop_disp,
    output logic [BIT_MODE_W-1:0] uop_bit_mode,
    output logic [3:0]            uop_len,
    output logic                  uop_illegal
);

    logic [2:0]            state_r;
    logic [7:0]            op_r;
    logic                  opsz16_r;
    logic                  rex_seen_r;
    logic                  rex_w_r;
    logic                  rex_r_r;
    logic                  rex_b_r;
    logic [2:0]            cnt_r;
    logic [2:0]            disp_bytes_r;
    logic [2:0]            imm_bytes_r;
    logic                  imm_signed_r;

    logic [OPCODE_W-1:0]   cls_micro_s;
    logic                  cls_needs_modrm_s;
    logic [1:0]            cls_disp_sel_s;
    logic [2:0]            cls_imm_bytes_s;
    logic                  cls_imm_signed_s;
    logic                  cls_illegal_s;
    logic [7:0]            cls_opcode_s;

    logic                  byte_take_s;
    logic                  is_opsz_s;
    logic                  is_rex_s;
    logic                  bad_s;
    logic                  clear_s;
    logic [3:0]            reg_idx_s;
    logic [3:0]            rm_idx_s;
    logic [BIT_MODE_W-1:0] bit_mode_s;
    logic [31:0]           imm_full_s;
    logic [31:0]           imm_final_s;
    logic [31:0]           disp_final_s;

    assign in_ready = (state_r != S_EMIT);

    x86_opcode_classify u_classify (
        .opcode      (cls_opcode_s),
        .modrm       (in_byte),
        .modrm_valid (state_r == S_MODRM),
        .rex_w       (rex_w_r),
        .opsz16      (opsz16_r),
        .micro       (cls_micro_s),
        .needs_modrm (cls_needs_modrm_s),
        .disp_sel    (cls_disp_sel_s),
        .imm_bytes   (cls_imm_bytes_s),
        .imm_signed  (cls_imm_signed_s),
        .illegal     (cls_illegal_s)
    );

    // Per-byte decode helpers: handshake, prefix detection, legality, field assembly.
    always_comb begin
        byte_take_s  = in_valid && (state_r != S_EMIT);
        clear_s      = rst || flush || ((state_r == S_EMIT) && uop_ready);
        is_opsz_s    = (in_byte == X86_PFX_OPSZ);
        is_rex_s     = (in_byte[7:4] == 4'h4);
        cls_opcode_s = (state_r == S_OP) ? in_byte : op_r;
        reg_idx_s    = {rex_r_r, in_byte[5:3]};
        rm_idx_s     = {rex_b_r, in_byte[2:0]};
        bit_mode_s   = rex_w_r ? BIT_MODE_64 : (opsz16_r ? BIT_MODE_16 : BIT_MODE_32);
        case (state_r)
            S_OP:    bad_s = is_opsz_s ? (opsz16_r || rex_seen_r) :
                             is_rex_s  ? rex_seen_r : cls_illegal_s;
            S_MODRM: bad_s = cls_illegal_s;
            default: bad_s = 1'b0;
        endcase
        imm_full_s   = le_assemble({in_byte, uop_imm[31:8]}, imm_bytes_r, imm_signed_r);
        imm_final_s  = (uop_opcode == MICRO_SLLI) ?
                       (imm_full_s & (rex_w_r ? 32'h0000_003F : 32'h0000_001F)) : imm_full_s;
        disp_final_s = le_assemble({in_byte, uop_disp[31:8]}, disp_bytes_r, 1'b1);
    end

    // Decoder FSM; uop_* registers are built up in place and held while valid.
    always_ff @(posedge clk) begin
        if (clear_s) begin
            state_r      <= S_OP;
            op_r         <= 8'h00;
            opsz16_r     <= 1'b0;
            rex_seen_r   <= 1'b0;
            rex_w_r      <= 1'b0;
            rex_r_r      <= 1'b0;
            rex_b_r      <= 1'b0;
            cnt_r        <= 3'd0;
            disp_bytes_r <= 3'd0;
            imm_bytes_r  <= 3'd0;
            imm_signed_r <= 1'b0;
            uop_valid    <= 1'b0;
            uop_opcode   <= MICRO_NONE;
            uop_rd       <= 4'd0;
            uop_rs       <= 4'd0;
            uop_rt       <= 4'd0;
            uop_imm      <= 32'd0;
            uop_disp     <= 32'd0;
            uop_bit_mode <= 2'd0;
            uop_len      <= 4'd0;
            uop_illegal  <= 1'b0;
        end else if (byte_take_s) begin
            uop_len <= uop_len + 4'd1;
            if (bad_s) begin
                uop_opcode  <= MICRO_NONE;
                uop_illegal <= 1'b1;
                uop_valid   <= 1'b1;
                state_r     <= S_EMIT;
            end else begin
                case (state_r)
                    S_OP: begin
                        if (is_opsz_s) begin
                            opsz16_r <= 1'b1;
                        end else if (is_rex_s) begin
                            rex_seen_r <= 1'b1;
                            rex_w_r    <= in_byte[3];
                            rex_r_r    <= in_byte[2];
                            rex_b_r    <= in_byte[0];
                        end else begin
                            op_r         <= in_byte;
                            uop_bit_mode <= bit_mode_s;
                            if (cls_needs_modrm_s) begin
                                state_r <= S_MODRM;
                            end else begin
                                uop_opcode   <= cls_micro_s;
                                uop_rd       <= rm_idx_s;
                                imm_bytes_r  <= cls_imm_bytes_s;
                                imm_signed_r <= cls_imm_signed_s;
                                cnt_r        <= cls_imm_bytes_s;
                                state_r      <= S_IMM;
                            end
                        end
                    end
                    S_MODRM: begin
                        uop_opcode   <= cls_micro_s;
                        imm_bytes_r  <= cls_imm_bytes_s;
                        imm_signed_r <= cls_imm_signed_s;
                        case (cls_micro_s)
                            MICRO_ADD, MICRO_XOR: begin
                                uop_rd <= rm_idx_s;
                                uop_rs <= rm_idx_s;
                                uop_rt <= reg_idx_s;
                            end
                            MICRO_MOV: begin
                                uop_rd <= rm_idx_s;
                                uop_rt <= reg_idx_s;
                            end
                            MICRO_LEA: begin
                                uop_rd <= reg_idx_s;
                                uop_rs <= rm_idx_s;
                            end
                            MICRO_MOVI: begin
                                uop_rd <= rm_idx_s;
                            end
                            default: begin
                                uop_rd <= rm_idx_s;
                                uop_rs <= rm_idx_s;
                            end
                        endcase
                        if (cls_disp_sel_s != DISP_NONE) begin
                            disp_bytes_r <= (cls_disp_sel_s == DISP_8) ? 3'd1 : 3'd4;
                            cnt_r        <= (cls_disp_sel_s == DISP_8) ? 3'd1 : 3'd4;
                            state_r      <= S_DISP;
                        end else if (cls_imm_bytes_s != 3'd0) begin
                            cnt_r   <= cls_imm_bytes_s;
                            state_r <= S_IMM;
                        end else begin
                            uop_valid <= 1'b1;
                            state_r   <= S_EMIT;
                        end
                    end
                    S_DISP: begin
                        if (cnt_r == 3'd1) begin
                            uop_disp <= disp_final_s;
                            if (imm_bytes_r != 3'd0) begin
                                cnt_r   <= imm_bytes_r;
                                state_r <= S_IMM;
                            end else begin
                                uop_valid <= 1'b1;
                                state_r   <= S_EMIT;
                            end
                        end else begin
                            uop_disp <= {in_byte, uop_disp[31:8]};
                            cnt_r    <= cnt_r - 3'd1;
                        end
                    end
                    S_IMM: begin
                        if (cnt_r == 3'd1) begin
                            uop_imm   <= imm_final_s;
                            uop_valid <= 1'b1;
                            state_r   <= S_EMIT;
                        end else begin
                            uop_imm <= {in_byte, uop_imm[31:8]};
                            cnt_r   <= cnt_r - 3'd1;
                        end
                    end
                    default: begin
                        state_r <= S_OP;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_x86_uop_decoder.sv
// Directed, table-driven bench for x86_uop_decoder plus hand-written
// sequences for backpressure, flush, stall and mid-instruction reset.
module tb_x86_uop_decoder;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_byte;
    logic        uop_valid;
    logic        uop_ready;
    logic [3:0]  uop_opcode;
    logic [3:0]  uop_rd;
    logic [3:0]  uop_rs;
    logic [3:0]  uop_rt;
    logic [31:0] uop_imm;
    logic [31:0] uop_disp;
    logic [1:0]  uop_bit_mode;
    logic [3:0]  uop_len;
    logic        uop_illegal;

    int total;
    int bad;

    // Micro-op codes: ADD=1 ADDI=2 SLLI=3 XOR=4 MOV=5 MOVI=6 LEA=7; bit_mode 16=1 32=2 64=3.
    typedef struct {
        string       name;
        logic [63:0] bytes;
        int          n;
        logic [3:0]  op;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [3:0]  rt;
        logic [31:0] imm;
        logic [31:0] disp;
        logic [1:0]  bm;
        logic [3:0]  len;
        logic        ill;
    } vec_t;

    vec_t vecs[$];

    x86_uop_decoder dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_byte      (in_byte),
        .uop_valid    (uop_valid),
        .uop_ready    (uop_ready),
        .uop_opcode   (uop_opcode),
        .uop_rd       (uop_rd),
        .uop_rs       (uop_rs),
        .uop_rt       (uop_rt),
        .uop_imm      (uop_imm),
        .uop_disp     (uop_disp),
        .uop_bit_mode (uop_bit_mode),
        .uop_len      (uop_len),
        .uop_illegal  (uop_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(string nm, logic [63:0] b, int n, logic [3:0] op,
                                logic [3:0] rd, logic [3:0] rs, logic [3:0] rt,
                                logic [31:0] imm, logic [31:0] disp, logic [1:0] bm,
                                logic [3:0] len, logic ill);
        vec_t v;
        v.name = nm; v.bytes = b; v.n = n; v.op = op; v.rd = rd; v.rs = rs; v.rt = rt;
        v.imm = imm; v.disp = disp; v.bm = bm; v.len = len; v.ill = ill;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_byte  = b;
        step();
        in_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        for (int i = 0; i < v.n; i++) begin
            chk($sformatf("%s in_ready[%0d]", v.name, i), 32'(in_ready), 32'd1);
            chk($sformatf("%s early_valid[%0d]", v.name, i), 32'(uop_valid), 32'd0);
            in_valid = 1'b1;
            in_byte  = v.bytes[8*(v.n-1-i) +: 8];
            step();
        end
        in_valid = 1'b0;
        chk({v.name, " uop_valid"}, 32'(uop_valid), 32'd1);
        chk({v.name, " opcode"},    32'(uop_opcode), 32'(v.op));
        chk({v.name, " illegal"},   32'(uop_illegal), 32'(v.ill));
        chk({v.name, " len"},       32'(uop_len), 32'(v.len));
        chk({v.name, " rd"},        32'(uop_rd), 32'(v.rd));
        chk({v.name, " rs"},        32'(uop_rs), 32'(v.rs));
        chk({v.name, " rt"},        32'(uop_rt), 32'(v.rt));
        chk({v.name, " imm"},       uop_imm, v.imm);
        chk({v.name, " disp"},      uop_disp, v.disp);
        if (!v.ill) begin
            chk({v.name, " bit_mode"}, 32'(uop_bit_mode), 32'(v.bm));
        end
        chk({v.name, " in_ready_emit"}, 32'(in_ready), 32'd0);
        uop_ready = 1'b1;
        step();
        uop_ready = 1'b0;
        chk({v.name, " valid_after_take"}, 32'(uop_valid), 32'd0);
        chk({v.name, " ready_after_take"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_byte = 8'h00; uop_ready = 1'b0;

        //          name            bytes                 n  op     rd     rs     rt     imm            disp           bm     len    ill
        vecs.push_back(mk("add64",   64'h4801D8,           3, 4'd1, 4'd0,  4'd0,  4'd3, 32'h0,        32'h0,         2'd3, 4'd3, 1'b0));
        vecs.push_back(mk("lea_d8",  64'h488D43F8,         4, 4'd7, 4'd0,  4'd3,  4'd0, 32'h0,        32'hFFFFFFF8,  2'd3, 4'd4, 1'b0));
        vecs.push_back(mk("lea_sib", 64'h488D04,           3, 4'd0, 4'd0,  4'd0,  4'd0, 32'h0,        32'h0,         2'd0, 4'd3, 1'b1));
        vecs.push_back(mk("addi16",  64'h6681C13412,       5, 4'd2, 4'd1,  4'd1,  4'd0, 32'h1234,     32'h0,         2'd1, 4'd5, 1'b0));
        vecs.push_back(mk("add32",   64'h01C8,             2, 4'd1, 4'd0,  4'd0,  4'd1, 32'h0,        32'h0,         2'd2, 4'd2, 1'b0));
        vecs.push_back(mk("movi_r8", 64'h41B878563412,     6, 4'd6, 4'd8,  4'd0,  4'd0, 32'h12345678, 32'h0,         2'd2, 4'd6, 1'b0));
        vecs.push_back(mk("esc0f",   64'h0F,               1, 4'd0, 4'd0,  4'd0,  4'd0, 32'h0,        32'h0,         2'd0, 4'd1, 1'b1));
        vecs.push_back(mk("slli64a", 64'h48C1E043,         4, 4'd3, 4'd0,  4'd0,  4'd0, 32'h03,       32'h0,         2'd3, 4'd4, 1'b0));
        vecs.push_back(mk("slli64b", 64'h48C1E23F,         4, 4'd3, 4'd2,  4'd2,  4'd0, 32'h3F,       32'h0,         2'd3, 4'd4, 1'b0));
        vecs.push_back(mk("slli32",  64'hC1E1FF,           3, 4'd3, 4'd1,  4'd1,  4'd0, 32'h1F,       32'h0,         2'd2, 4'd3, 1'b0));
        vecs.push_back(mk("addi8",   64'h83C3FF,           3, 4'd2, 4'd3,  4'd3,  4'd0, 32'hFFFFFFFF, 32'h0,         2'd2, 4'd3, 1'b0));
        vecs.push_back(mk("movi_c7", 64'hC7C200000080,     6, 4'd6, 4'd2,  4'd0,  4'd0, 32'h80000000, 32'h0,         2'd2, 4'd6, 1'b0));
        vecs.push_back(mk("movi16",  64'h66B8FEFF,         4, 4'd6, 4'd0,  4'd0,  4'd0, 32'hFFFFFFFE, 32'h0,         2'd1, 4'd4, 1'b0));
        vecs.push_back(mk("lea_d32", 64'h8D8078563412,     6, 4'd7, 4'd0,  4'd0,  4'd0, 32'h0,        32'h12345678,  2'd2, 4'd6, 1'b0));
        vecs.push_back(mk("lea_d0",  64'h8D0B,             2, 4'd7, 4'd1,  4'd3,  4'd0, 32'h0,        32'h0,         2'd2, 4'd2, 1'b0));
        vecs.push_back(mk("lea_rip", 64'h8D05,             2, 4'd0, 4'd0,  4'd0,  4'd0, 32'h0,        32'h0,         2'd0, 4'd2, 1'b1));
        vecs.push_back(mk("lea_reg", 64'h8DC0,             2, 4'd0, 4'd0,  4'd0,  4'd0, 32'h0,        32'h0,         2'd0, 4'd2, 1'b1));
        vecs.push_back(mk("dup66",   64'h6666,             2, 4'd0, 4'd0,  4'd0,  4'd0, 32'h0,        32'h0,         2'd0, 4'd2, 1'b1));
        vecs.push_back(mk("duprex",  64'h4841,             2, 4'd0, 4'd0,  4'd0,  4'd0, 32'h0,        32'h0,         2'd0, 4'd2, 1'b1));
        vecs.push_back(mk("rex_66",  64'h4866,             2, 4'd0, 4'd0,  4'd0,  4'd0, 32'h0,        32'h0,         2'd0, 4'd2, 1'b1));
        vecs.push_back(mk("movi_w",  64'h48B8,             2, 4'd0, 4'd0,  4'd0,  4'd0, 32'h0,        32'h0,         2'd0, 4'd2, 1'b1));
        vecs.push_back(mk("add_mem", 64'h0100,             2, 4'd0, 4'd0,  4'd0,  4'd0, 32'h0,        32'h0,         2'd0, 4'd2, 1'b1));
        vecs.push_back(mk("addi_/1", 64'h81C8,             2, 4'd0, 4'd0,  4'd0,  4'd0, 32'h0,        32'h0,         2'd0, 4'd2, 1'b1));
        vecs.push_back(mk("w_over66",64'h6648C7C011223344, 8, 4'd6, 4'd0,  4'd0,  4'd0, 32'h44332211, 32'h0,         2'd3, 4'd8, 1'b0));
        vecs.push_back(mk("rex_r",   64'h4C01C0,           3, 4'd1, 4'd0,  4'd0,  4'd8, 32'h0,        32'h0,         2'd3, 4'd3, 1'b0));
        vecs.push_back(mk("rex_b",   64'h4931C3,           3, 4'd4, 4'd11, 4'd11, 4'd0, 32'h0,        32'h0,         2'd3, 4'd3, 1'b0));

        step(); step();
        rst = 1'b0;
        chk("reset uop_valid",  32'(uop_valid), 32'd0);
        chk("reset in_ready",   32'(in_ready), 32'd1);
        chk("reset opcode",     32'(uop_opcode), 32'd0);
        chk("reset len",        32'(uop_len), 32'd0);
        chk("reset illegal",    32'(uop_illegal), 32'd0);
        chk("reset imm",        uop_imm, 32'd0);

        for (int k = 0; k < vecs.size(); k++) begin
            run_vec(vecs[k]);
        end

        // Backpressure: 31 C0 held for three cycles while a byte is offered.
        send(8'h31); send(8'hC0);
        in_valid = 1'b1; in_byte = 8'h01;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("hold valid[%0d]", k),    32'(uop_valid), 32'd1);
            chk($sformatf("hold in_ready[%0d]", k), 32'(in_ready), 32'd0);
            chk($sformatf("hold opcode[%0d]", k),   32'(uop_opcode), 32'd4);
            chk($sformatf("hold len[%0d]", k),      32'(uop_len), 32'd2);
            chk($sformatf("hold rd[%0d]", k),       32'(uop_rd), 32'd0);
            chk($sformatf("hold bm[%0d]", k),       32'(uop_bit_mode), 32'd2);
            step();
        end
        uop_ready = 1'b1;
        step();
        uop_ready = 1'b0; in_valid = 1'b0;
        chk("hold released", 32'(uop_valid), 32'd0);

        // Flush mid-instruction: the byte offered with flush is dropped.
        send(8'h48); send(8'h81); send(8'hC0); send(8'h01);
        chk("preflush valid", 32'(uop_valid), 32'd0);
        in_valid = 1'b1; in_byte = 8'h89; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush valid",    32'(uop_valid), 32'd0);
        chk("flush in_ready", 32'(in_ready), 32'd1);
        chk("flush len",      32'(uop_len), 32'd0);
        run_vec(mk("mov_after_flush", 64'h89D8, 2, 4'd5, 4'd0, 4'd0, 4'd3, 32'h0, 32'h0, 2'd2, 4'd2, 1'b0));

        // Input stall mid-instruction: state holds.
        send(8'h48); send(8'h01);
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("stall valid[%0d]", k),    32'(uop_valid), 32'd0);
            chk($sformatf("stall in_ready[%0d]", k), 32'(in_ready), 32'd1);
        end
        run_vec(mk("stall_add", 64'hD8, 1, 4'd1, 4'd0, 4'd0, 4'd3, 32'h0, 32'h0, 2'd3, 4'd3, 1'b0));

        // Reset after a prefix: prefix must not leak into the next instruction.
        send(8'h66);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid len", 32'(uop_len), 32'd0);
        run_vec(mk("after_rst", 64'h01C8, 2, 4'd1, 4'd0, 4'd0, 4'd1, 32'h0, 32'h0, 2'd2, 4'd2, 1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
